mrelbp_column_streamer: RTL

//  Raster-to-column front end for the MRELBP CI R2 stage (R2_top). Accepts one 8-bit pixel per

---
 rtl/mrelbp_pkg.sv | 21 ++
 rtl/mrelbp_line_buffer.sv | 32 +++
 rtl/mrelbp_column_streamer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mrelbp_pkg.sv
// Shared definitions for the MRELBP raster-to-column front end: FSM state
// encoding and the number of chained line buffers.
package mrelbp_pkg;

    // Frame sequencing states; DONE lasts exactly one cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Four previous rows are needed to form a 5-tall column.
    localparam int LB_COUNT = 4;

    // True in the states where pixels are accepted into the line buffers.
    function automatic logic is_active(input state_e st);
        return (st == FILL) || (st == STREAM);
    endfunction

endpackage

// File: rtl/mrelbp_line_buffer.sv
// One row of pixel storage. A single address is shared by the write and the
// read port; the read is asynchronous so it returns the value stored before
// this cycle's write lands on the clock edge (read-before-write). Chaining
// several of these shifts a whole row down by one line per accepted pixel.
module mrelbp_line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 640,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Row storage write port.
    // NOTE: storage has no reset so it maps onto RAM primitives; every entry
    // is rewritten during FILL before any column reads it.
    // NOTE: sequential state is assigned with <= so all flops sample
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mrelbp_column_streamer.sv
// Raster-to-column front end for the MRELBP CI R2 stage. Pixels arrive in
// raster order; once four full rows are buffered, every accepted pixel
// produces a registered vertical column S1 (row r-4) .. S5 (row r).
module mrelbp_column_streamer
    import mrelbp_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] pixel_i,
    output logic              done_o,
    output logic [DATA_W-1:0] S1,
    output logic [DATA_W-1:0] S2,
    output logic [DATA_W-1:0] S3,
    output logic [DATA_W-1:0] S4,
    output logic [DATA_W-1:0] S5,
    output logic              frame_done_o,
    output logic              busy_o
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_FILL_LAST = ROW_W'(LB_COUNT - 1);

    state_e state_q, state_d;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    logic              done_q, done_d;
    logic [DATA_W-1:0] s1_q, s2_q, s3_q, s4_q, s5_q;

    logic accept;
    logic col_last;

    logic [DATA_W-1:0] lb_wdata [LB_COUNT];
    logic [DATA_W-1:0] lb_rdata [LB_COUNT];

    // A pixel is taken only while a frame is active; a start_i in the same
    // cycle restarts the frame and drops that pixel.
    assign accept   = valid_i && !start_i && is_active(state_q);
    assign col_last = (col_q == COL_LAST);

    // Columns are produced only once the four history rows are in place.
    assign done_d = accept && (state_q == STREAM);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: start_i restarts from FILL unless in DONE.
    // NOTE: every combinational output is defaulted first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = FILL;
            end
            FILL: begin
                if (start_i) begin
                    state_d = FILL;
                end else if (accept && col_last && (row_q == ROW_FILL_LAST)) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (start_i) begin
                    state_d = FILL;
                end else if (accept && col_last && (row_q == ROW_LAST)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs, decoded straight from the state register.
    always_comb begin
        busy_o       = is_active(state_q);
        frame_done_o = (state_q == DONE);
    end

    // Raster position: cleared outside an active frame and on restart,
    // advanced once per accepted pixel with the column wrapping into row++.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (!is_active(state_q) || start_i) begin
            col_d = '0;
            row_d = '0;
        end else if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Raster position registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // LB0 takes the incoming pixel; each further buffer takes the old
    // contents of the one above it at the same column.
    assign lb_wdata[0] = pixel_i;

    for (genvar k = 0; k < LB_COUNT; k++) begin : g_lb
        if (k > 0) begin : g_chain
            assign lb_wdata[k] = lb_rdata[k-1];
        end

        mrelbp_line_buffer #(
            .DATA_W (DATA_W),
            .DEPTH  (IMG_WIDTH)
        ) u_lb (
            .clk     (clk),
            .we_i    (accept),
            .addr_i  (col_q),
            .wdata_i (lb_wdata[k]),
            .rdata_o (lb_rdata[k])
        );
    end

    // Column output stage: load on a produced column, hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b0;
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            s4_q   <= '0;
            s5_q   <= '0;
        end else begin
            done_q <= done_d;
            if (done_d) begin
                s1_q <= lb_rdata[3];
                s2_q <= lb_rdata[2];
                s3_q <= lb_rdata[1];
                s4_q <= lb_rdata[0];
                s5_q <= pixel_i;
            end
        end
    end

    assign done_o = done_q;
    assign S1     = s1_q;
    assign S2     = s2_q;
    assign S3     = s3_q;
    assign S4     = s4_q;
    assign S5     = s5_q;

endmodule
